// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;

   // Empty pipeline slot: used for both reset and redirect flush.
   localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic        d_valid,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_pc_plus4,
   input  logic [31:0] d_instr,
   output logic        q_valid,
   output logic [31:0] q_pc,
   output logic [31:0] q_pc_plus4,
   output logic [31:0] q_instr
);

   if_id_t q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= IF_ID_BUBBLE;
      end else if (flush) begin
         q_reg <= IF_ID_BUBBLE;
      end else if (!hold) begin
         q_reg <= '{valid: d_valid, pc: d_pc, pc_plus4: d_pc_plus4, instr: d_instr};
      end
   end

   assign q_valid    = q_reg.valid;
   assign q_pc       = q_reg.pc;
   assign q_pc_plus4 = q_reg.pc_plus4;
   assign q_instr    = q_reg.instr;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT sequencing, issue counter and IF/ID capture.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      imem_address,
   input  logic [31:0]      imem_instruction,
   output logic             if_id_valid,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_pc_plus4,
   output logic [31:0]      if_id_instruction,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   fetch_state_t     state_reg, state_next;
   logic [31:0]      pc_reg, pc_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [31:0]      pc_plus4;
   logic             ifid_hold, ifid_flush;
   if_id_t           ifid_d;

   assign pc_plus4 = pc_reg + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= BOOT;
         pc_reg    <= RESET_PC;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      count_next = count_reg;
      ifid_hold  = 1'b1;
      ifid_flush = 1'b0;
      ifid_d     = '{valid: 1'b1, pc: pc_reg, pc_plus4: pc_plus4, instr: imem_instruction};

      // Redirect wins over stall and state; the word fetched this cycle is dropped.
      if (redirect_valid) begin
         pc_next    = redirect_pc & 32'hFFFF_FFFC;
         ifid_flush = 1'b1;
         state_next = RUN;
      end else begin
         case (state_reg)
            BOOT: begin
               state_next = RUN;
            end
            RUN: begin
               if (!stall) begin
                  ifid_hold  = 1'b0;
                  count_next = count_reg + CNT_W'(1);
                  if (imem_instruction == EBREAK_INSTR) begin
                     state_next = HALT;
                  end else begin
                     pc_next = pc_plus4;
                  end
               end
            end
            HALT: begin
               // Drain the EBREAK out of IF/ID but keep its PC fields.
               if (!stall) begin
                  ifid_hold = 1'b0;
                  ifid_d    = '{valid: 1'b0, pc: if_id_pc, pc_plus4: if_id_pc_plus4, instr: NOP_INSTR};
               end
            end
            default: begin
               state_next = BOOT;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .hold       (ifid_hold),
      .flush      (ifid_flush),
      .d_valid    (ifid_d.valid),
      .d_pc       (ifid_d.pc),
      .d_pc_plus4 (ifid_d.pc_plus4),
      .d_instr    (ifid_d.instr),
      .q_valid    (if_id_valid),
      .q_pc       (if_id_pc),
      .q_pc_plus4 (if_id_pc_plus4),
      .q_instr    (if_id_instruction)
   );

   assign imem_address = pc_reg;
   assign halted       = (state_reg == HALT);
   assign fetch_count  = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 16-word behavioural instruction memory.
module tb_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instruction;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] mem [16];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          n_assert;
   int          n_fail;
   logic [31:0] exp_pc;
   logic [31:0] exp_count;

   fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_address      (imem_address),
      .imem_instruction  (imem_instruction),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .if_id_instruction (if_id_instruction),
      .halted            (halted),
      .fetch_count       (fetch_count)
   );

   assign imem_instruction = mem[imem_address[5:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
      chk({tag, "_pc"}, if_id_pc, 32'h0);
      chk({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
      chk({tag, "_instr"}, if_id_instruction, NOP);
      chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
      chk({tag, "_count"}, fetch_count, 32'h0);
      chk({tag, "_addr"}, imem_address, 32'h0);
   endtask

   // One unstalled RUN cycle: expectation queued from the bench's own PC, checked after the edge.
   task automatic fetch_one(input string tag);
      exp_t e;
      logic [31:0] w;
      chk({tag, "_addr"}, imem_address, exp_pc);
      w = mem[exp_pc[5:2]];
      e.pc = exp_pc;
      e.instr = w;
      sb.push_back(e);
      stall = 1'b0;
      redirect_valid = 1'b0;
      tick();
      exp_count = exp_count + 32'd1;
      if (w != EBREAK) exp_pc = exp_pc + 32'd4;
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h1);
      chk({tag, "_pc"}, if_id_pc, e.pc);
      chk({tag, "_pc4"}, if_id_pc_plus4, e.pc + 32'd4);
      chk({tag, "_instr"}, if_id_instruction, e.instr);
      chk({tag, "_count"}, fetch_count, exp_count);
      $display("fetch %s pc=0x%08h instr=0x%08h count=%0d", tag, if_id_pc, if_id_instruction, fetch_count);
   endtask

   task automatic redirect_to(input string tag, input logic [31:0] target, input logic stall_v);
      redirect_valid = 1'b1;
      redirect_pc = target;
      stall = stall_v;
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      exp_pc = {target[31:2], 2'b00};
      chk({tag, "_addr"}, imem_address, exp_pc);
      chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
      chk({tag, "_instr"}, if_id_instruction, NOP);
      chk({tag, "_pc"}, if_id_pc, 32'h0);
      chk({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
      chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
      chk({tag, "_count"}, fetch_count, exp_count);
      $display("redirect %s target=0x%08h pc=0x%08h", tag, target, imem_address);
   endtask

   initial begin
      n_assert = 0;
      n_fail = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h00A0_0013 + (i << 20);
      mem[0]  = 32'h0000_00B3;
      mem[1]  = 32'h0010_8133;
      mem[4]  = 32'h0040_0213;
      mem[5]  = 32'h0080_0293;
      mem[11] = 32'h0001_D603;

      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      #3;
      check_reset("reset");
      tick();
      rst = 1'b0;
      exp_pc = 32'h0;
      exp_count = 32'h0;

      // Bubble cycle out of BOOT
      tick();
      chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
      chk("boot_addr", imem_address, 32'h0);
      $display("boot pc=0x%08h valid=%0d", imem_address, if_id_valid);

      fetch_one("t1_w0");
      chk("t1_w0_const", if_id_instruction, 32'h0000_00B3);
      fetch_one("t1_w1");
      chk("t1_pc8", imem_address, 32'h0000_0008);
      chk("t1_w1_const", if_id_instruction, 32'h0010_8133);

      fetch_one("t2_w2");
      fetch_one("t2_w3");
      fetch_one("t2_w4");
      chk("t2_w4_const", if_id_instruction, 32'h0040_0213);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_addr", imem_address, 32'h0000_0014);
         chk("t2_stall_instr", if_id_instruction, 32'h0040_0213);
         chk("t2_stall_pc", if_id_pc, 32'h0000_0010);
         chk("t2_stall_count", fetch_count, 32'd5);
         $display("stall cycle %0d pc=0x%08h", i, imem_address);
      end
      fetch_one("t2_w5");
      chk("t2_w5_const", if_id_instruction, 32'h0080_0293);

      redirect_to("t3_redir", 32'h0000_002E, 1'b1);
      chk("t3_pc2c", imem_address, 32'h0000_002C);
      fetch_one("t3_w11");
      chk("t3_w11_const", if_id_instruction, 32'h0001_D603);

      // EBREAK at word 4
      mem[4] = EBREAK;
      redirect_to("t4_redir", 32'h0000_0010, 1'b0);
      fetch_one("t4_ebreak");
      chk("t4_halted", {31'h0, halted}, 32'h1);
      chk("t4_hold_addr", imem_address, 32'h0000_0010);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t4_drain_valid", {31'h0, if_id_valid}, 32'h0);
         chk("t4_drain_instr", if_id_instruction, NOP);
         chk("t4_drain_halted", {31'h0, halted}, 32'h1);
         chk("t4_drain_addr", imem_address, 32'h0000_0010);
         chk("t4_drain_count", fetch_count, exp_count);
         $display("halt cycle %0d pc=0x%08h valid=%0d", i, imem_address, if_id_valid);
      end
      mem[4] = 32'h0040_0213;
      redirect_to("t4_resume", 32'h0000_0000, 1'b0);
      fetch_one("t4_w0");

      // Fresh reset, then 16 straight fetches to wrap the memory index
      rst = 1'b1;
      #2;
      check_reset("t5_reset");
      tick();
      rst = 1'b0;
      exp_pc = 32'h0;
      exp_count = 32'h0;
      tick();
      for (int i = 0; i < 16; i++) fetch_one("t5_run");
      chk("t5_pc40", imem_address, 32'h0000_0040);
      chk("t5_count16", fetch_count, 32'd16);
      fetch_one("t5_wrap");
      chk("t5_wrap_instr", if_id_instruction, 32'h0000_00B3);
      redirect_to("t5_top", 32'hFFFF_FFFC, 1'b0);
      fetch_one("t5_last");
      chk("t5_pc_wrap", imem_address, 32'h0000_0000);
      chk("t5_pc4_wrap", if_id_pc_plus4, 32'h0000_0000);

      // Halt with stall held, then async reset mid-cycle
      mem[7] = EBREAK;
      redirect_to("t6_redir", 32'h0000_001C, 1'b0);
      fetch_one("t6_ebreak");
      stall = 1'b1;
      tick();
      chk("t6_keep_valid", {31'h0, if_id_valid}, 32'h1);
      chk("t6_keep_instr", if_id_instruction, EBREAK);
      chk("t6_keep_halted", {31'h0, halted}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_reset("t6_async");
      $display("async reset at t=%0t valid=%0d halted=%0d", $time, if_id_valid, halted);
      tick();
      rst = 1'b0;
      stall = 1'b0;

      chk("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
